// File: rtl/logic_unit_pipe.sv
// Purpose : handshaked logic-gate bank (NOT/AND/OR/NAND/NOR/XOR/XNOR) feeding a 2-entry result FIFO.
// Latency : 1 cycle; an op accepted at edge N is on out_* right after edge N when the buffer was empty.
// Backpr. : in_ready = !FULL (registered state only); head is held stable while out_ready is low.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake; in_op selects gate (7 = illegal), in_a/in_b operands
//   out_valid/out_ready downstream handshake; out_data result, out_zero/out_ones/out_err head flags
//   perf_count          16-bit saturating pop counter, present only with LOGIC_UNIT_PIPE_PERF_EN
//
// Optional feature macro: LOGIC_UNIT_PIPE_PERF_EN
module logic_unit_pipe #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_err
`ifdef LOGIC_UNIT_PIPE_PERF_EN
    ,
    output logic [15:0]      perf_count
`endif
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
        $error("logic_unit_pipe: WIDTH=%0d outside legal range 1..64", WIDTH);
    end

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             zero;
        logic             ones;
        logic             err;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    entry_t head;
    entry_t tail;
    entry_t new_ent;

    logic [WIDTH-1:0] g_not;
    logic [WIDTH-1:0] g_and;
    logic [WIDTH-1:0] g_or;
    logic [WIDTH-1:0] g_nand;
    logic [WIDTH-1:0] g_nor;
    logic [WIDTH-1:0] g_xor;
    logic [WIDTH-1:0] g_xnor;
    logic [WIDTH-1:0] sel_res;
    logic             illegal;
    logic             accept;
    logic             pop;

    // Full gate bank evaluated in parallel; the opcode only steers the mux.
    assign g_not  = ~in_a;
    assign g_and  = in_a & in_b;
    assign g_or   = in_a | in_b;
    assign g_nand = ~(in_a & in_b);
    assign g_nor  = ~(in_a | in_b);
    assign g_xor  = in_a ^ in_b;
    assign g_xnor = ~(in_a ^ in_b);

    assign illegal = (in_op == 3'd7);

    always_comb begin
        sel_res = '0;
        case (in_op)
            3'd0:    sel_res = g_not;
            3'd1:    sel_res = g_and;
            3'd2:    sel_res = g_or;
            3'd3:    sel_res = g_nand;
            3'd4:    sel_res = g_nor;
            3'd5:    sel_res = g_xor;
            3'd6:    sel_res = g_xnor;
            default: sel_res = '0;   // illegal op stores a zero result
        endcase
    end

    // Illegal op forces result 0, so zero=1 and ones=0 fall out naturally.
    always_comb begin
        new_ent      = '0;
        new_ent.data = sel_res;
        new_ent.zero = (sel_res == '0);
        new_ent.ones = (sel_res == '1);
        new_ent.err  = illegal;
    end

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_data = head.data;
    assign out_zero = head.zero;
    assign out_ones = head.ones;
    assign out_err  = head.err;

    // Occupancy FSM with head/tail storage. In ONE with simultaneous
    // accept and pop the head is overwritten, giving 1 op/cycle with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head  <= new_ent;
                        state <= ONE;
                    end
                end
                ONE: begin
                    case ({accept, pop})
                        2'b10: begin
                            tail  <= new_ent;
                            state <= FULL;
                        end
                        2'b01: state <= EMPTY;
                        2'b11: head  <= new_ent;
                        default: ;
                    endcase
                end
                FULL: begin
                    if (pop) begin
                        head  <= tail;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef LOGIC_UNIT_PIPE_PERF_EN
    // Saturating pop counter; holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_count <= 16'd0;
        end else if (pop && (perf_count != 16'hFFFF)) begin
            perf_count <= perf_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_op = 3'd0;
    logic [3:0] in_a = 4'h0;
    logic [3:0] in_b = 4'h0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic       out_zero;
    logic       out_ones;
    logic       out_err;
`ifdef LOGIC_UNIT_PIPE_PERF_EN
    logic [15:0] perf_count;
`endif

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_ops [0:6];

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_ones  (out_ones),
        .out_err   (out_err)
`ifdef LOGIC_UNIT_PIPE_PERF_EN
        ,
        .perf_count(perf_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    initial begin
        exp_ops[0] = 4'h3; exp_ops[1] = 4'h8; exp_ops[2] = 4'hE; exp_ops[3] = 4'h7;
        exp_ops[4] = 4'h1; exp_ops[5] = 4'h6; exp_ops[6] = 4'h9;

        // Reset state
        step(); step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_flags",     {29'd0, out_zero, out_ones, out_err}, 32'd0);
        #3 rst_n = 1'b1;

        // Single AND
        out_ready = 1'b1;
        drive(1'b1, 3'd1, 4'b1100, 4'b1010);
        step();
        chk("and_valid", 32'(out_valid), 32'd1);
        chk("and_data",  32'(out_data),  32'h8);
        chk("and_flags", {29'd0, out_zero, out_ones, out_err}, 32'd0);
        drive(1'b0, 3'd0, 4'h0, 4'h0);
        step();
        chk("and_drained", 32'(out_valid), 32'd0);

        // Ops 0..6 back to back
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 3'(i), 4'hC, 4'hA);
            chk($sformatf("b2b_rdy%0d", i), 32'(in_ready), 32'd1);
            step();
            chk($sformatf("b2b_data%0d", i), 32'(out_data), 32'(exp_ops[i]));
            chk($sformatf("b2b_vld%0d", i), 32'(out_valid), 32'd1);
        end

        // XOR equal operands -> zero; OR with all-ones -> ones
        drive(1'b1, 3'd5, 4'h5, 4'h5);
        step();
        chk("xor_data", 32'(out_data), 32'h0);
        chk("xor_zero", 32'(out_zero), 32'd1);
        drive(1'b1, 3'd2, 4'hF, 4'h0);
        step();
        chk("or_data", 32'(out_data), 32'hF);
        chk("or_ones", 32'(out_ones), 32'd1);
        chk("or_zero", 32'(out_zero), 32'd0);
        drive(1'b0, 3'd0, 4'h0, 4'h0);
        step();
        chk("b2b_drained", 32'(out_valid), 32'd0);

        // Backpressure: fill, hold third op, drain in order
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 4'hC, 4'hA);      // 8
        step();
        chk("bp_rdy1",  32'(in_ready), 32'd1);
        chk("bp_head1", 32'(out_data), 32'h8);
        drive(1'b1, 3'd2, 4'hC, 4'hA);      // E
        step();
        chk("bp_rdy2",  32'(in_ready), 32'd0);
        chk("bp_head2", 32'(out_data), 32'h8);
        drive(1'b1, 3'd6, 4'hC, 4'hA);      // 9, held upstream
        step(); step();
        chk("bp_hold_rdy",  32'(in_ready),  32'd0);
        chk("bp_hold_data", 32'(out_data),  32'h8);
        chk("bp_hold_vld",  32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        chk("bp_drain1", 32'(out_data), 32'hE);
        chk("bp_rdy3",   32'(in_ready), 32'd1);
        step();
        chk("bp_drain2", 32'(out_data), 32'h9);
        drive(1'b0, 3'd0, 4'h0, 4'h0);
        step();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Streaming in ONE for 11 accepts: result of OR(k,0) = k each cycle
        for (int k = 0; k < 11; k++) begin
            drive(1'b1, 3'd2, 4'(k), 4'h0);
            step();
            chk($sformatf("stream_data%0d", k), 32'(out_data), 32'(k));
            chk($sformatf("stream_rdy%0d", k), 32'(in_ready), 32'd1);
        end
        drive(1'b0, 3'd0, 4'h0, 4'h0);
        step();

        // Illegal opcode
        out_ready = 1'b0;
        drive(1'b1, 3'd7, 4'hF, 4'hF);
        step();
        chk("ill_vld",  32'(out_valid), 32'd1);
        chk("ill_data", 32'(out_data),  32'h0);
        chk("ill_flags", {29'd0, out_zero, out_ones, out_err}, 32'b101);
        out_ready = 1'b1;
        drive(1'b1, 3'd1, 4'hF, 4'hF);
        step();
        chk("post_ill_data",  32'(out_data), 32'hF);
        chk("post_ill_flags", {29'd0, out_zero, out_ones, out_err}, 32'b010);
        drive(1'b0, 3'd0, 4'h0, 4'h0);
        step();

        // Async reset while FULL
        out_ready = 1'b0;
        drive(1'b1, 3'd2, 4'h3, 4'h4);
        step();
        drive(1'b1, 3'd2, 4'h5, 4'h2);
        step();
        chk("full_rdy", 32'(in_ready), 32'd0);
        drive(1'b0, 3'd0, 4'h0, 4'h0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_vld",  32'(out_valid), 32'd0);
        chk("arst_rdy",  32'(in_ready),  32'd1);
        chk("arst_data", 32'(out_data),  32'd0);
`ifdef LOGIC_UNIT_PIPE_PERF_EN
        chk("arst_perf", 32'(perf_count), 32'd0);
`endif
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("arst_lost", 32'(out_valid), 32'd0);

`ifdef LOGIC_UNIT_PIPE_PERF_EN
        drive(1'b1, 3'd1, 4'h1, 4'h1);
        step();
        drive(1'b0, 3'd0, 4'h0, 4'h0);
        step();
        chk("perf_one", 32'(perf_count), 32'd1);
        drive(1'b1, 3'd1, 4'h1, 4'h1);
        for (int n = 0; n < 65540; n++) step();
        chk("perf_sat", 32'(perf_count), 32'hFFFF);
        step();
        chk("perf_sat_hold", 32'(perf_count), 32'hFFFF);
        drive(1'b0, 3'd0, 4'h0, 4'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
